// File: rtl/glue_logic_tester.sv
// glue_logic_tester
//   Built-in exerciser for the four-output glue logic block. It steps all 16
//   input combinations onto the block's IN4..IN7 pins. Each vector is held for
//   a programmable settle time. The block's OUT4..OUT7 are then compared
//   against an internal reference model. At the end of a run the tester
//   reports an error count, the first failing vector and a pass flag.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before its result is sampled (1..255)
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   start       begin a run; only honoured in IDLE or FINISH
//   vec_out     vector driven to the glue block (bit0->IN4 .. bit3->IN7)
//   res_in      glue block outputs (bit0<-OUT4 .. bit3<-OUT7)
//   busy        run in progress (SETTLE or CHECK)
//   done        run complete; held until the next start or rst
//   pass        done with no mismatches
//   err_cnt     number of mismatching vectors, 0..16
//   fail_seen   at least one mismatch in the current run
//   first_fail  vector of the first mismatch; valid while fail_seen is high

module glue_logic_tester #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] vec_out,
  input  logic [3:0] res_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic       fail_seen,
  output logic [3:0] first_fail
);

  // The counter is loaded with SETTLE_CYCLES-1 and leaves SETTLE when it
  // reaches zero, so SETTLE lasts exactly SETTLE_CYCLES cycles.
  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    FINISH
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] settle_cnt;
  logic [7:0] settle_cnt_nxt;
  logic [3:0] vec_nxt;
  logic [4:0] err_cnt_nxt;
  logic       fail_seen_nxt;
  logic [3:0] first_fail_nxt;
  logic       done_nxt;

  logic       in_a;
  logic       in_b;
  logic       in_c;
  logic       in_d;
  logic [3:0] exp_res;
  logic       mismatch;

  // Reference model of the glue block, evaluated on the vector currently driven.
  always_comb begin
    in_a       = vec_out[0];
    in_b       = vec_out[1];
    in_c       = vec_out[2];
    in_d       = vec_out[3];
    exp_res[0] = (in_a & in_b) | ~in_c;
    exp_res[1] = in_a | in_b;
    exp_res[2] = in_a ^ in_b;
    exp_res[3] = ~(in_c ^ in_d);
    mismatch   = (res_in != exp_res);
  end

  // Next-state and next-datapath logic. Every register holds unless the
  // current state says otherwise.
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    vec_nxt        = vec_out;
    err_cnt_nxt    = err_cnt;
    fail_seen_nxt  = fail_seen;
    first_fail_nxt = first_fail;
    done_nxt       = done;

    unique case (state)
      IDLE, FINISH: begin
        if (start) begin
          vec_nxt        = 4'd0;
          settle_cnt_nxt = RELOAD;
          err_cnt_nxt    = 5'd0;
          fail_seen_nxt  = 1'b0;
          first_fail_nxt = 4'd0;
          done_nxt       = 1'b0;
          state_nxt      = SETTLE;
        end
      end

      SETTLE: begin
        if (settle_cnt == 8'd0) begin
          state_nxt = CHECK;
        end else begin
          settle_cnt_nxt = settle_cnt - 8'd1;
        end
      end

      CHECK: begin
        // Only the first mismatch of a run is latched into first_fail.
        if (mismatch) begin
          err_cnt_nxt = err_cnt + 5'd1;
          if (!fail_seen) begin
            first_fail_nxt = vec_out;
            fail_seen_nxt  = 1'b1;
          end
        end
        if (vec_out == 4'd15) begin
          done_nxt  = 1'b1;
          state_nxt = FINISH;
        end else begin
          vec_nxt        = vec_out + 4'd1;
          settle_cnt_nxt = RELOAD;
          state_nxt      = SETTLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= 8'd0;
      vec_out    <= 4'd0;
      err_cnt    <= 5'd0;
      fail_seen  <= 1'b0;
      first_fail <= 4'd0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      vec_out    <= vec_nxt;
      err_cnt    <= err_cnt_nxt;
      fail_seen  <= fail_seen_nxt;
      first_fail <= first_fail_nxt;
      done       <= done_nxt;
    end
  end

  // Status outputs. pass can never be high during a run because done is
  // cleared on the same edge that starts one.
  always_comb begin
    busy = (state == SETTLE) || (state == CHECK);
    pass = done && (err_cnt == 5'd0);
  end

endmodule

// File: tb/tb_glue_logic_tester.sv
// tb_glue_logic_tester
//   Directed bench for glue_logic_tester. Two instances are used: one with
//   the default settle time and one with SETTLE_CYCLES=1. A behavioural glue
//   block, held as a hand-filled truth table, drives res_in. It can be
//   corrupted in two ways (bit 2 stuck at 0, bit 3 inverted) to provoke
//   mismatches.

module tb_glue_logic_tester;

  logic       clk;
  logic       rst;
  logic       start0;
  logic       start1;
  logic [3:0] vec_out0;
  logic [3:0] vec_out1;
  logic [3:0] res_in0;
  logic [3:0] res_in1;
  logic       busy0;
  logic       busy1;
  logic       done0;
  logic       done1;
  logic       pass0;
  logic       pass1;
  logic [4:0] err_cnt0;
  logic [4:0] err_cnt1;
  logic       fail_seen0;
  logic       fail_seen1;
  logic [3:0] first_fail0;
  logic [3:0] first_fail1;

  int checks;
  int errors;
  int mode;
  int dsel;
  int run_cycles;
  int wait_cnt;

  // Expected glue outputs, indexed by {d,c,b,a}.
  logic [3:0] golden_tab [16];

  logic       busy_s;
  logic       done_s;
  logic       pass_s;
  logic [3:0] vec_s;
  logic [4:0] err_s;
  logic       fs_s;
  logic [3:0] ff_s;

  glue_logic_tester #(.SETTLE_CYCLES(4)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .start      (start0),
    .vec_out    (vec_out0),
    .res_in     (res_in0),
    .busy       (busy0),
    .done       (done0),
    .pass       (pass0),
    .err_cnt    (err_cnt0),
    .fail_seen  (fail_seen0),
    .first_fail (first_fail0)
  );

  glue_logic_tester #(.SETTLE_CYCLES(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .vec_out    (vec_out1),
    .res_in     (res_in1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .err_cnt    (err_cnt1),
    .fail_seen  (fail_seen1),
    .first_fail (first_fail1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural glue block, optionally faulted, for each instance.
  always_comb begin
    res_in0 = golden_tab[vec_out0];
    if (mode == 1) res_in0 = golden_tab[vec_out0] & 4'b1011;
    else if (mode == 2) res_in0 = golden_tab[vec_out0] ^ 4'b1000;
    res_in1 = golden_tab[vec_out1];
  end

  // Observation mux so one run task serves both instances.
  always_comb begin
    busy_s = (dsel == 0) ? busy0       : busy1;
    done_s = (dsel == 0) ? done0       : done1;
    pass_s = (dsel == 0) ? pass0       : pass1;
    vec_s  = (dsel == 0) ? vec_out0    : vec_out1;
    err_s  = (dsel == 0) ? err_cnt0    : err_cnt1;
    fs_s   = (dsel == 0) ? fail_seen0  : fail_seen1;
    ff_s   = (dsel == 0) ? first_fail0 : first_fail1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start on the selected instance and follow the run until done.
  // The vector at each cycle must equal cycles/(settle+1).
  task automatic applyStimulus(input int sel, input int settle, input int inject_at,
                               output int cycles);
    int hold_bad;
    dsel = sel;
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    checkOutput("start_busy", 32'(busy_s), 32'd1);
    checkOutput("start_vec",  32'(vec_s),  32'd0);
    checkOutput("start_done", 32'(done_s), 32'd0);
    checkOutput("start_err",  32'(err_s),  32'd0);
    checkOutput("start_fs",   32'(fs_s),   32'd0);
    checkOutput("start_pass", 32'(pass_s), 32'd0);
    cycles   = 0;
    hold_bad = 0;
    while (!done_s && cycles < 400) begin
      if (busy_s && (vec_s != 4'(cycles / (settle + 1)))) hold_bad++;
      if (cycles == inject_at) begin
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
      end
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      cycles++;
    end
    checkOutput("vec_hold",    32'(hold_bad), 32'd0);
    checkOutput("end_busy",    32'(busy_s),   32'd0);
    checkOutput("end_vec",     32'(vec_s),    32'd15);
  endtask

  initial begin
    golden_tab = '{4'h9, 4'hF, 4'hF, 4'hB, 4'h0, 4'h6, 4'h6, 4'h3,
                   4'h1, 4'h7, 4'h7, 4'h3, 4'h8, 4'hE, 4'hE, 4'hB};
    checks = 0;
    errors = 0;
    mode   = 0;
    dsel   = 0;
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_vec",  32'(vec_out0),    32'd0);
    checkOutput("rst_busy", 32'(busy0),       32'd0);
    checkOutput("rst_done", 32'(done0),       32'd0);
    checkOutput("rst_pass", 32'(pass0),       32'd0);
    checkOutput("rst_err",  32'(err_cnt0),    32'd0);
    checkOutput("rst_fs",   32'(fail_seen0),  32'd0);
    checkOutput("rst_ff",   32'(first_fail0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] golden run, mid-run start at cycle 20 ignored");
    mode = 0;
    applyStimulus(0, 4, 20, run_cycles);
    checkOutput("gold_len",  32'(run_cycles), 32'd80);
    checkOutput("gold_pass", 32'(pass0),      32'd1);
    checkOutput("gold_err",  32'(err_cnt0),   32'd0);
    checkOutput("gold_fs",   32'(fail_seen0), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("gold_held", 32'(done0),      32'd1);

    $display("[TB] res_in[2] stuck at 0, restarted from FINISH");
    mode = 1;
    applyStimulus(0, 4, -1, run_cycles);
    checkOutput("s0_len",  32'(run_cycles),  32'd80);
    checkOutput("s0_err",  32'(err_cnt0),    32'd8);
    checkOutput("s0_ff",   32'(first_fail0), 32'd1);
    checkOutput("s0_fs",   32'(fail_seen0),  32'd1);
    checkOutput("s0_pass", 32'(pass0),       32'd0);

    $display("[TB] res_in[3] inverted");
    mode = 2;
    applyStimulus(0, 4, -1, run_cycles);
    checkOutput("inv_len",  32'(run_cycles),  32'd80);
    checkOutput("inv_err",  32'(err_cnt0),    32'd16);
    checkOutput("inv_ff",   32'(first_fail0), 32'd0);
    checkOutput("inv_pass", 32'(pass0),       32'd0);

    $display("[TB] SETTLE_CYCLES=1 golden run");
    applyStimulus(1, 1, -1, run_cycles);
    checkOutput("s1_len",  32'(run_cycles), 32'd32);
    checkOutput("s1_pass", 32'(pass1),      32'd1);
    checkOutput("s1_err",  32'(err_cnt1),   32'd0);
    dsel = 0;

    $display("[TB] reset while vector 7 is driven");
    mode   = 2;
    start0 = 1'b1;
    @(negedge clk);
    start0   = 1'b0;
    wait_cnt = 0;
    while (vec_out0 != 4'd7 && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("mid_vec7", 32'(vec_out0), 32'd7);
    checkOutput("mid_err",  32'(err_cnt0), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mr_vec",  32'(vec_out0),   32'd0);
    checkOutput("mr_busy", 32'(busy0),      32'd0);
    checkOutput("mr_done", 32'(done0),      32'd0);
    checkOutput("mr_err",  32'(err_cnt0),   32'd0);
    checkOutput("mr_fs",   32'(fail_seen0), 32'd0);
    @(negedge clk);
    checkOutput("mr_idle", 32'(busy0),      32'd0);
    mode = 0;
    applyStimulus(0, 4, -1, run_cycles);
    checkOutput("mr_len",  32'(run_cycles), 32'd80);
    checkOutput("mr_pass", 32'(pass0),      32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
